// File: rtl/axi4_w_order_router.sv
// W-channel order router for one slave port of the AXI4 crossbar.
//
// AW handshakes won at this slave are recorded as {master, len} in a small order FIFO.
// W beats are forwarded from the master at the FIFO head, one full burst at a time.
// The slave WLAST comes from a beat counter compared against the recorded AWLEN. A master
// whose own WLAST disagrees with that counter is reported on err_wlast.
//
// Ports:
//   ACLK, ARESET          clock and synchronous active-high reset
//   aw_push/master/len    AW handshake to this slave: winning master and its AWLEN
//   aw_order_ready        order FIFO has room; slave AWVALID must be held low when 0
//   m_w*                  packed per-master W channels, master i at slice i
//   s_w*                  slave W channel
//   fifo_count            occupied order-FIFO entries
//   err_wlast             one-cycle pulse after a beat whose master WLAST was wrong
//   err_overflow          sticky flag: aw_push arrived while the FIFO was full
module axi4_w_order_router #(
  parameter int unsigned MASTER_NUM  = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned W_BUF_DEPTH = 2,
  localparam int unsigned MID_W  = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int unsigned CNT_W  = $clog2(W_BUF_DEPTH + 1),
  localparam int unsigned STRB_W = DATA_WIDTH / 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           aw_push,
  input  logic [MID_W-1:0]               aw_master,
  input  logic [7:0]                     aw_len,
  output logic                           aw_order_ready,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_wdata,
  input  logic [MASTER_NUM*STRB_W-1:0]   m_wstrb,
  input  logic [MASTER_NUM-1:0]          m_wlast,
  input  logic [MASTER_NUM-1:0]          m_wvalid,
  output logic [MASTER_NUM-1:0]          m_wready,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [STRB_W-1:0]              s_wstrb,
  output logic                           s_wlast,
  output logic                           s_wvalid,
  input  logic                           s_wready,
  output logic [CNT_W-1:0]               fifo_count,
  output logic                           err_wlast,
  output logic                           err_overflow
);

  localparam int unsigned PTR_W = (W_BUF_DEPTH > 1) ? $clog2(W_BUF_DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StRoute} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic               err_wlast_q, err_wlast_d;
  logic               err_ovf_q, err_ovf_d;

  // Order FIFO storage; only pointers and count carry reset state.
  logic [MID_W-1:0]   mst_q [W_BUF_DEPTH];
  logic [7:0]         len_q [W_BUF_DEPTH];

  logic [MID_W-1:0]   head_mst;
  logic [7:0]         head_len;
  logic               push_en;
  logic               beat_acc;
  logic               is_last;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(W_BUF_DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign head_mst       = mst_q[rd_ptr_q];
  assign head_len       = len_q[rd_ptr_q];
  // No bypass: a pop in this cycle does not free a slot for a push in this cycle.
  assign aw_order_ready = (count_q != CNT_W'(W_BUF_DEPTH));
  assign push_en        = aw_push && aw_order_ready;
  assign is_last        = (beat_cnt_q == head_len);
  assign beat_acc       = s_wvalid && s_wready;
  assign pop            = beat_acc && is_last;

  assign fifo_count   = count_q;
  assign err_wlast    = err_wlast_q;
  assign err_overflow = err_ovf_q;

  // Combinational W routing from the head master.
  always_comb begin
    s_wvalid = 1'b0;
    s_wdata  = '0;
    s_wstrb  = '0;
    s_wlast  = 1'b0;
    m_wready = '0;
    if (state_q == StRoute) begin
      s_wvalid = m_wvalid[head_mst];
      if (s_wvalid) begin
        s_wdata = m_wdata[head_mst*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb = m_wstrb[head_mst*STRB_W +: STRB_W];
      end
      s_wlast            = s_wvalid && is_last;
      m_wready[head_mst] = s_wready;
    end
  end

  // Next-state: FIFO pointers/count, beat counter, error flags, FSM.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_cnt_d  = beat_cnt_q;
    err_wlast_d = 1'b0;
    err_ovf_d   = err_ovf_q | (aw_push && !aw_order_ready);
    state_d     = state_q;

    if (push_en) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (beat_acc) begin
      // Burst boundary follows the counter; master WLAST is only checked.
      beat_cnt_d  = is_last ? 8'd0 : beat_cnt_q + 8'd1;
      err_wlast_d = (m_wlast[head_mst] != is_last);
    end

    unique case (state_q)
      StIdle: begin
        if (push_en) begin
          state_d = StRoute;
        end
      end
      StRoute: begin
        if (pop && (count_d == '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      err_wlast_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      err_wlast_q <= err_wlast_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_en) begin
      mst_q[wr_ptr_q] <= aw_master;
      len_q[wr_ptr_q] <= aw_len;
    end
  end

endmodule

// File: tb/tb_axi4_w_order_router.sv
module tb_axi4_w_order_router;

  localparam int unsigned MN = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic            ACLK;
  logic            ARESET;
  logic            aw_push;
  logic [1:0]      aw_master;
  logic [7:0]      aw_len;
  logic            aw_order_ready;
  logic [MN*DW-1:0] m_wdata;
  logic [MN*SW-1:0] m_wstrb;
  logic [MN-1:0]   m_wlast;
  logic [MN-1:0]   m_wvalid;
  logic [MN-1:0]   m_wready;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_wlast;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      fifo_count;
  logic            err_wlast;
  logic            err_overflow;

  axi4_w_order_router #(
    .MASTER_NUM  (MN),
    .DATA_WIDTH  (DW),
    .W_BUF_DEPTH (2)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .aw_push        (aw_push),
    .aw_master      (aw_master),
    .aw_len         (aw_len),
    .aw_order_ready (aw_order_ready),
    .m_wdata        (m_wdata),
    .m_wstrb        (m_wstrb),
    .m_wlast        (m_wlast),
    .m_wvalid       (m_wvalid),
    .m_wready       (m_wready),
    .s_wdata        (s_wdata),
    .s_wstrb        (s_wstrb),
    .s_wlast        (s_wlast),
    .s_wvalid       (s_wvalid),
    .s_wready       (s_wready),
    .fifo_count     (fifo_count),
    .err_wlast      (err_wlast),
    .err_overflow   (err_overflow)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   mlen[MN];
  int   mforce[MN];
  int   mbeat[MN];
  bit   mact[MN];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_master(input int i, input bit v, input bit l, input logic [63:0] d,
                            input logic [7:0] s);
    m_wvalid[i]         = v;
    m_wlast[i]          = l;
    m_wdata[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW] = s;
  endtask

  task automatic clr_masters();
    m_wvalid = '0;
    m_wlast  = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
  endtask

  task automatic push_aw(input logic [1:0] m, input logic [7:0] len);
    aw_push   = 1'b1;
    aw_master = m;
    aw_len    = len;
    tick();
    aw_push = 1'b0;
  endtask

  function automatic logic [63:0] beat_data(input int m, input int b);
    return {32'(m), 32'(b)};
  endfunction

  task automatic push_exp(input int m, input int len);
    exp_t e;
    for (int b = 0; b <= len; b++) begin
      e.d = beat_data(m, b);
      e.l = (b == len);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_master(input int m, input int len, input int force_at);
    mact[m]   = 1'b1;
    mlen[m]   = len;
    mforce[m] = force_at;
    mbeat[m]  = 0;
  endtask

  // Drives active masters beat by beat and compares every accepted slave beat against exp_q.
  task automatic run_stream(input int budget, input bit toggle, input logic [3:0] bad_rdy_mask,
                            output int wl_pulses);
    int cyc;
    bit bad_rdy;
    cyc       = 0;
    bad_rdy   = 1'b0;
    wl_pulses = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      s_wready = toggle ? ((cyc % 2) == 0) : 1'b1;
      for (int i = 0; i < MN; i++) begin
        if (mact[i]) begin
          set_master(i, 1'b1, (mbeat[i] == mlen[i]) || (mbeat[i] == mforce[i]),
                     beat_data(i, mbeat[i]), 8'(mbeat[i] + i));
        end else begin
          set_master(i, 1'b0, 1'b0, 64'd0, 8'd0);
        end
      end
      #1;
      if (err_wlast) wl_pulses++;
      if ((m_wready & bad_rdy_mask) != 4'd0) bad_rdy = 1'b1;
      if (s_wvalid && s_wready) begin
        check_eq("stream_data", s_wdata, exp_q[0].d);
        check_eq("stream_last", 64'(s_wlast), 64'(exp_q[0].l));
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < MN; i++) begin
        if (m_wvalid[i] && m_wready[i]) begin
          mbeat[i]++;
          if (mbeat[i] > mlen[i]) mact[i] = 1'b0;
        end
      end
      cyc++;
      tick();
    end
    check_eq("stream_done_left", 64'(exp_q.size()), 64'd0);
    check_eq("stream_bad_wready", 64'(bad_rdy), 64'd0);
    exp_q.delete();
    for (int i = 0; i < MN; i++) mact[i] = 1'b0;
    clr_masters();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    ARESET    = 1'b1;
    aw_push   = 1'b0;
    aw_master = '0;
    aw_len    = '0;
    s_wready  = 1'b0;
    clr_masters();
    for (int i = 0; i < MN; i++) begin
      mact[i] = 1'b0; mlen[i] = 0; mforce[i] = -1; mbeat[i] = 0;
    end
    tick();
    tick();
    ARESET = 1'b0;

    // Reset state
    check_eq("rst_fifo_count", 64'(fifo_count), 64'd0);
    check_eq("rst_aw_ready", 64'(aw_order_ready), 64'd1);
    check_eq("rst_m_wready", 64'(m_wready), 64'd0);
    check_eq("rst_s_wvalid", 64'(s_wvalid), 64'd0);
    check_eq("rst_s_wlast", 64'(s_wlast), 64'd0);
    check_eq("rst_s_wdata", s_wdata, 64'd0);
    check_eq("rst_s_wstrb", 64'(s_wstrb), 64'd0);
    check_eq("rst_err_wlast", 64'(err_wlast), 64'd0);
    check_eq("rst_err_ovf", 64'(err_overflow), 64'd0);

    // Single burst: master 2, len 3; master 0 also valid and must stay stalled
    s_wready = 1'b1;
    push_aw(2'd2, 8'd3);
    check_eq("single_count", 64'(fifo_count), 64'd1);
    for (int b = 0; b < 4; b++) begin
      set_master(2, 1'b1, b == 3, 64'hA000 + 64'(b), 8'(b + 1));
      set_master(0, 1'b1, 1'b1, 64'hDEAD, 8'hFF);
      #1;
      check_eq("single_valid", 64'(s_wvalid), 64'd1);
      check_eq("single_data", s_wdata, 64'hA000 + 64'(b));
      check_eq("single_strb", 64'(s_wstrb), 64'(b + 1));
      check_eq("single_last", 64'(s_wlast), 64'(b == 3));
      check_eq("single_wready", 64'(m_wready), 64'b0100);
      tick();
    end
    clr_masters();
    #1;
    check_eq("single_end_count", 64'(fifo_count), 64'd0);
    check_eq("single_end_valid", 64'(s_wvalid), 64'd0);
    check_eq("single_end_data", s_wdata, 64'd0);
    check_eq("single_end_wready", 64'(m_wready), 64'd0);
    check_eq("single_err_wlast", 64'(err_wlast), 64'd0);

    // Ordering: m1 len 0 then m3 len 1; m3 asserts valid first
    tick();
    aw_push   = 1'b1;
    aw_master = 2'd1;
    aw_len    = 8'd0;
    set_master(3, 1'b1, 1'b0, 64'h3000, 8'h33);
    tick();
    aw_master = 2'd3;
    aw_len    = 8'd1;
    #1;
    check_eq("order_m3_stalled", 64'(m_wready), 64'b0010);
    check_eq("order_no_valid", 64'(s_wvalid), 64'd0);
    tick();
    aw_push = 1'b0;
    set_master(1, 1'b1, 1'b1, 64'h1000, 8'h11);
    #1;
    check_eq("order_count2", 64'(fifo_count), 64'd2);
    check_eq("order_m1_data", s_wdata, 64'h1000);
    check_eq("order_m1_last", 64'(s_wlast), 64'd1);
    check_eq("order_m1_wready", 64'(m_wready), 64'b0010);
    tick();
    set_master(1, 1'b0, 1'b0, 64'd0, 8'd0);
    #1;
    check_eq("order_m3b0_data", s_wdata, 64'h3000);
    check_eq("order_m3b0_last", 64'(s_wlast), 64'd0);
    check_eq("order_m3b0_wready", 64'(m_wready), 64'b1000);
    check_eq("order_count1", 64'(fifo_count), 64'd1);
    tick();
    set_master(3, 1'b1, 1'b1, 64'h3001, 8'h33);
    #1;
    check_eq("order_m3b1_data", s_wdata, 64'h3001);
    check_eq("order_m3b1_last", 64'(s_wlast), 64'd1);
    tick();
    clr_masters();
    #1;
    check_eq("order_end_count", 64'(fifo_count), 64'd0);
    check_eq("order_err_wlast", 64'(err_wlast), 64'd0);

    // Full FIFO, dropped push, backpressure toggling
    s_wready = 1'b0;
    push_aw(2'd0, 8'd1);
    push_aw(2'd2, 8'd0);
    check_eq("full_count", 64'(fifo_count), 64'd2);
    check_eq("full_aw_ready", 64'(aw_order_ready), 64'd0);
    push_aw(2'd1, 8'd0);
    check_eq("full_err_ovf", 64'(err_overflow), 64'd1);
    check_eq("full_count_after_drop", 64'(fifo_count), 64'd2);
    push_exp(0, 1);
    push_exp(2, 0);
    start_master(0, 1, -1);
    start_master(2, 0, -1);
    start_master(1, 0, -1);
    run_stream(40, 1'b1, 4'b0010, pulses);
    check_eq("full_wlast_pulses", 64'(pulses), 64'd0);
    #1;
    check_eq("full_end_count", 64'(fifo_count), 64'd0);
    check_eq("full_end_aw_ready", 64'(aw_order_ready), 64'd1);
    check_eq("full_err_ovf_sticky", 64'(err_overflow), 64'd1);

    // WLAST mismatch: len 2, master asserts WLAST on beat 2
    push_aw(2'd2, 8'd2);
    push_exp(2, 2);
    start_master(2, 2, 1);
    run_stream(20, 1'b0, 4'b1011, pulses);
    if (err_wlast) pulses++;
    check_eq("wlast_err_pulses", 64'(pulses), 64'd1);
    check_eq("wlast_end_count", 64'(fifo_count), 64'd0);

    // Maximum length burst: 256 beats
    push_aw(2'd3, 8'd255);
    push_exp(3, 255);
    start_master(3, 255, -1);
    run_stream(400, 1'b0, 4'b0111, pulses);
    check_eq("max_wlast_pulses", 64'(pulses), 64'd0);
    check_eq("max_end_count", 64'(fifo_count), 64'd0);

    // Five back-to-back len-0 bursts, push and pop together
    s_wready = 1'b1;
    push_aw(2'd0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      aw_push   = (k < 4);
      aw_master = 2'((k + 1) % 4);
      aw_len    = 8'd0;
      clr_masters();
      set_master(k % 4, 1'b1, 1'b1, 64'h5000 + 64'(k), 8'hFF);
      #1;
      check_eq("b2b_valid", 64'(s_wvalid), 64'd1);
      check_eq("b2b_data", s_wdata, 64'h5000 + 64'(k));
      check_eq("b2b_last", 64'(s_wlast), 64'd1);
      check_eq("b2b_count", 64'(fifo_count), 64'd1);
      tick();
    end
    aw_push = 1'b0;
    clr_masters();
    #1;
    check_eq("b2b_end_count", 64'(fifo_count), 64'd0);
    check_eq("b2b_end_valid", 64'(s_wvalid), 64'd0);
    check_eq("b2b_err_wlast", 64'(err_wlast), 64'd0);

    // Reset on beat 2 of a len-7 burst
    push_aw(2'd1, 8'd7);
    set_master(1, 1'b1, 1'b0, 64'h7000, 8'hFF);
    tick();
    set_master(1, 1'b1, 1'b0, 64'h7001, 8'hFF);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check_eq("mrst_count", 64'(fifo_count), 64'd0);
    check_eq("mrst_s_wvalid", 64'(s_wvalid), 64'd0);
    check_eq("mrst_m_wready", 64'(m_wready), 64'd0);
    check_eq("mrst_err_ovf", 64'(err_overflow), 64'd0);
    check_eq("mrst_err_wlast", 64'(err_wlast), 64'd0);
    check_eq("mrst_aw_ready", 64'(aw_order_ready), 64'd1);
    clr_masters();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
